mem_copy_master: RTL

//  Initiator side of the data-memory port: a word-copy engine driving Memory's

---
 rtl/mem_copy_if.sv | 23 ++
 rtl/mem_copy_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_copy_if.sv
// Data-memory port bundle between the copy engine (master) and the memory (slave).
// Names follow the memory's own port names (addrRe/MemRead/read_data, addr/write_data/MemWrite).
interface mem_copy_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0] addrRe;
  logic          MemRead;
  logic [DW-1:0] read_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic          MemWrite;

  modport master (
    output addrRe, MemRead, addr, write_data, MemWrite,
    input  read_data
  );

  modport slave (
    input  addrRe, MemRead, addr, write_data, MemWrite,
    output read_data
  );
endinterface

// File: rtl/mem_copy_master.sv
// Word-copy engine: copies len words src->dst as read, wait RD_LAT cycles, write.
// Optional macro MEM_COPY_CHECKSUM_EN adds a running checksum of written words.
module mem_copy_master #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
`ifdef MEM_COPY_CHECKSUM_EN
  input  logic          clr_sum,
  output logic [DW-1:0] checksum,
`endif
  mem_copy_if.master    mem
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  // WAIT spans RD_LAT cycles; the down-counter is loaded with RD_LAT-1
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   index_q, index_d;
  logic [1:0]    wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_re_q, addr_re_d;
  logic [AW-1:0] addr_wr_q, addr_wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    index_d = index_q;
    wait_d  = wait_q;
    wdata_d = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef MEM_COPY_CHECKSUM_EN
        if (start || clr_sum) sum_d = '0;
`endif
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          index_d = '0;
          state_d = (len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (RD_LAT == 0) begin
          wdata_d = mem.read_data;
          state_d = S_WR;
        end else begin
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          wdata_d = mem.read_data;
          state_d = S_WR;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_WR: begin
`ifdef MEM_COPY_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        index_d = index_q + (AW+1)'(1);
        state_d = (index_d == len_q) ? S_DONE : S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered
    busy_d    = (state_d == S_RD) || (state_d == S_WAIT) || (state_d == S_WR);
    done_d    = (state_d == S_DONE);
    rd_d      = (state_d == S_RD);
    wr_d      = (state_d == S_WR);
    addr_re_d = rd_d ? (src_d + index_d[AW-1:0]) : addr_re_q;
    addr_wr_d = wr_d ? (dst_d + index_d[AW-1:0]) : addr_wr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      index_q   <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_re_q <= '0;
      addr_wr_q <= '0;
      wdata_q   <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      index_q   <= index_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_re_q <= addr_re_d;
      addr_wr_q <= addr_wr_d;
      wdata_q   <= wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem.MemRead    = rd_q;
  assign mem.MemWrite   = wr_q;
  assign mem.addrRe     = addr_re_q;
  assign mem.addr       = addr_wr_q;
  assign mem.write_data = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum       = sum_q;
`endif

endmodule
